// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads the async ROM and buffers
// {pc, instr} in a small prefetch FIFO handed to decode over valid/ready.
//
// Ports:
//   clk, rst        - clock, async active-high reset
//   fetch_en        - allow PC advance / FIFO pushes
//   rom_addr        - ROM byte address (== pc)
//   rom_rdata       - ROM word, combinational from rom_addr
//   redirect_valid  - flush and reload PC from redirect_pc
//   redirect_pc     - redirect target (forced word aligned)
//   out_valid/ready - decode handshake
//   out_instr/pc    - FIFO head contents
//   perf_fetched/stalls/flushes - only when FETCH_PERF_EN is defined
module instr_fetch #(
   parameter int               WIDTH      = 32,
   parameter logic [WIDTH-1:0] RESET_PC   = '0,
   parameter int               FIFO_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fetch_en,
   output logic [WIDTH-1:0] rom_addr,
   input  logic [WIDTH-1:0] rom_rdata,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_instr,
`ifdef FETCH_PERF_EN
   output logic [WIDTH-1:0] out_pc,
   output logic [31:0]      perf_fetched,
   output logic [31:0]      perf_stalls,
   output logic [31:0]      perf_flushes
`else
   output logic [WIDTH-1:0] out_pc
`endif
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      OCC_EMPTY,
      OCC_PARTIAL,
      OCC_FULL
   } occ_t;

   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] mem_pc    [FIFO_DEPTH];
   logic [WIDTH-1:0] mem_instr [FIFO_DEPTH];
   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;
   logic [CW-1:0]    count;
   occ_t             occ;
   logic             push;
   logic             pop;

   always_comb begin
      occ = OCC_PARTIAL;
      if (count == '0)
         occ = OCC_EMPTY;
      else if (count == DEPTH_C)
         occ = OCC_FULL;
   end

   assign out_valid = (occ != OCC_EMPTY);
   assign pop  = out_valid & out_ready & ~redirect_valid;
   // A full FIFO can still accept a word when the head leaves this cycle.
   assign push = fetch_en & ~redirect_valid & ((occ != OCC_FULL) | pop);

   assign rom_addr  = pc;
   assign out_pc    = mem_pc[rptr];
   assign out_instr = mem_instr[rptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc    <= {RESET_PC[WIDTH-1:2], 2'b00};
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (redirect_valid) begin
         pc    <= {redirect_pc[WIDTH-1:2], 2'b00};
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            pc   <= pc + WIDTH'(4);
            wptr <= (wptr == PW'(FIFO_DEPTH - 1)) ? '0 : wptr + PW'(1);
         end
         if (pop)
            rptr <= (rptr == PW'(FIFO_DEPTH - 1)) ? '0 : rptr + PW'(1);
         if (push && !pop)
            count <= count + CW'(1);
         else if (pop && !push)
            count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_pc[i]    <= '0;
            mem_instr[i] <= '0;
         end
      end else if (push) begin
         mem_pc[wptr]    <= pc;
         mem_instr[wptr] <= rom_rdata;
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetched <= '0;
         perf_stalls  <= '0;
         perf_flushes <= '0;
      end else begin
         if (push)
            perf_fetched <= perf_fetched + 32'd1;
         if (fetch_en && !redirect_valid && !push)
            perf_stalls <= perf_stalls + 32'd1;
         if (redirect_valid)
            perf_flushes <= perf_flushes + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a combinational ROM model
// (word n at byte address 4n holds 32'h1000_0000 + n).
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_en;
   logic [31:0] rom_addr;
   logic [31:0] rom_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_stalls;
   logic [31:0] perf_flushes;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   assign rom_rdata = 32'h1000_0000 + {2'b00, rom_addr[31:2]};

   instr_fetch dut (
      .clk            (clk),
      .rst            (rst),
      .fetch_en       (fetch_en),
      .rom_addr       (rom_addr),
      .rom_rdata      (rom_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
`ifdef FETCH_PERF_EN
      .out_pc         (out_pc),
      .perf_fetched   (perf_fetched),
      .perf_stalls    (perf_stalls),
      .perf_flushes   (perf_flushes)
`else
      .out_pc         (out_pc)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      fetch_en       = 1'b0;
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      rst            = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid got=%0b exp=0", out_valid);
      end
      checks++;
      if (rom_addr !== 32'h0) begin
         errors++;
         $display("FAIL reset_addr got=%h exp=0", rom_addr);
      end
      checks++;
      if (out_pc !== 32'h0 || out_instr !== 32'h0) begin
         errors++;
         $display("FAIL reset_head got=%h/%h exp=0/0", out_pc, out_instr);
      end
   endtask

   task automatic test_sequential();
      do_reset();
      fetch_en  = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         checks++;
         if (out_valid !== 1'b1 || out_pc !== 32'(4 * k)
             || out_instr !== 32'h1000_0000 + 32'(k)) begin
            errors++;
            $display("FAIL seq_head%0d got=%0b %h %h exp=1 %h %h", k,
                     out_valid, out_pc, out_instr, 32'(4 * k),
                     32'h1000_0000 + 32'(k));
         end
         checks++;
         if (rom_addr !== 32'(4 * (k + 1))) begin
            errors++;
            $display("FAIL seq_addr%0d got=%h exp=%h", k, rom_addr,
                     32'(4 * (k + 1)));
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_addr [5];
      exp_addr = '{32'h4, 32'h8, 32'h8, 32'h8, 32'h8};
      do_reset();
      fetch_en  = 1'b1;
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         checks++;
         if (rom_addr !== exp_addr[k] || out_pc !== 32'h0
             || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold%0d got=%h %h %0b exp=%h 0 1", k,
                     rom_addr, out_pc, out_valid, exp_addr[k]);
         end
      end
      out_ready = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         step();
         checks++;
         if (out_pc !== 32'(4 * k) || out_valid !== 1'b1
             || rom_addr !== 32'(4 * k + 8)) begin
            errors++;
            $display("FAIL bp_drain%0d got=%h %0b %h exp=%h 1 %h", k,
                     out_pc, out_valid, rom_addr, 32'(4 * k),
                     32'(4 * k + 8));
         end
      end
   endtask

   task automatic test_redirect_full();
      do_reset();
      fetch_en  = 1'b1;
      out_ready = 1'b0;
      step();
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0103;
      out_ready      = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b0 || rom_addr !== 32'h100) begin
         errors++;
         $display("FAIL redir_flush got=%0b %h exp=0 00000100",
                  out_valid, rom_addr);
      end
      redirect_valid = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h100
          || out_instr !== 32'h1000_0040) begin
         errors++;
         $display("FAIL redir_target got=%0b %h %h exp=1 100 10000040",
                  out_valid, out_pc, out_instr);
      end
      step();
      checks++;
      if (out_pc !== 32'h104) begin
         errors++;
         $display("FAIL redir_next got=%h exp=104", out_pc);
      end
   endtask

   task automatic test_redirect_hold();
      do_reset();
      fetch_en       = 1'b1;
      out_ready      = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      step();
      redirect_pc = 32'h302;
      step();
      checks++;
      if (out_valid !== 1'b0 || rom_addr !== 32'h300) begin
         errors++;
         $display("FAIL hold_flush got=%0b %h exp=0 300",
                  out_valid, rom_addr);
      end
      redirect_valid = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h300) begin
         errors++;
         $display("FAIL hold_target got=%0b %h exp=1 300",
                  out_valid, out_pc);
      end
   endtask

   task automatic test_pc_wrap();
      do_reset();
      fetch_en       = 1'b1;
      out_ready      = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      step();
      checks++;
      if (rom_addr !== 32'hFFFF_FFFC || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL wrap_redir got=%h %0b exp=fffffffc 0",
                  rom_addr, out_valid);
      end
      redirect_valid = 1'b0;
      step();
      checks++;
      if (out_pc !== 32'hFFFF_FFFC || out_instr !== 32'h4FFF_FFFF
          || rom_addr !== 32'h0) begin
         errors++;
         $display("FAIL wrap_last got=%h %h %h exp=fffffffc 4fffffff 0",
                  out_pc, out_instr, rom_addr);
      end
      step();
      checks++;
      if (out_pc !== 32'h0 || out_instr !== 32'h1000_0000) begin
         errors++;
         $display("FAIL wrap_zero got=%h %h exp=0 10000000",
                  out_pc, out_instr);
      end
   endtask

   task automatic test_fetch_en_low_and_reset();
      do_reset();
      fetch_en  = 1'b1;
      out_ready = 1'b0;
      step();
      step();
      fetch_en  = 1'b0;
      out_ready = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h4 || rom_addr !== 32'h8) begin
         errors++;
         $display("FAIL fen_pop1 got=%0b %h %h exp=1 4 8",
                  out_valid, out_pc, rom_addr);
      end
      step();
      checks++;
      if (out_valid !== 1'b0 || rom_addr !== 32'h8) begin
         errors++;
         $display("FAIL fen_pop2 got=%0b %h exp=0 8", out_valid, rom_addr);
      end
      step();
      checks++;
      if (out_valid !== 1'b0 || rom_addr !== 32'h8) begin
         errors++;
         $display("FAIL fen_empty got=%0b %h exp=0 8", out_valid, rom_addr);
      end
      fetch_en = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h8 || rom_addr !== 32'hC) begin
         errors++;
         $display("FAIL fen_resume got=%0b %h %h exp=1 8 c",
                  out_valid, out_pc, rom_addr);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || rom_addr !== 32'h0 || out_pc !== 32'h0) begin
         errors++;
         $display("FAIL async_rst got=%0b %h %h exp=0 0 0",
                  out_valid, rom_addr, out_pc);
      end
      step();
      rst = 1'b0;
   endtask

`ifdef FETCH_PERF_EN
   task automatic test_perf();
      do_reset();
      checks++;
      if (perf_fetched !== 0 || perf_stalls !== 0 || perf_flushes !== 0) begin
         errors++;
         $display("FAIL perf_reset got=%0d %0d %0d exp=0 0 0",
                  perf_fetched, perf_stalls, perf_flushes);
      end
      fetch_en  = 1'b1;
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) step();
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      step();
      redirect_valid = 1'b0;
      fetch_en       = 1'b0;
      checks++;
      if (perf_fetched !== 32'd10 || perf_stalls !== 32'd3
          || perf_flushes !== 32'd1) begin
         errors++;
         $display("FAIL perf_counts got=%0d %0d %0d exp=10 3 1",
                  perf_fetched, perf_stalls, perf_flushes);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_sequential();
      test_backpressure();
      test_redirect_full();
      test_redirect_hold();
      test_pc_wrap();
      test_fetch_en_low_and_reset();
`ifdef FETCH_PERF_EN
      test_perf();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage directly upstream of the asynchronous instruction ROM.
- Owns the program counter and drives the ROM word address combinationally.
- Captures the returned word together with its PC into a small prefetch FIFO.
- Presents {pc, instr} to decode over a valid/ready handshake; decode redirects fetch on taken branches and jumps.

Parameters:
- WIDTH, 32, data and address width (matches ROM WIDTH)
- RESET_PC, 32'h0000_0000, PC value after reset
- FIFO_DEPTH, 2, prefetch buffer entries; power of two, at least 2

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- fetch_en  input  1  fetch permitted; low freezes PC and pushes, pops still allowed
- rom_addr  output  WIDTH  byte address to ROM; always equals pc, low 2 bits always 0
- rom_rdata  input  WIDTH  ROM read data, combinational from rom_addr
- redirect_valid  input  1  branch/jump redirect request
- redirect_pc  input  WIDTH  redirect target byte address
- out_valid  output  1  FIFO head is valid
- out_ready  input  1  decode accepts head this cycle
- out_instr  output  WIDTH  instruction at FIFO head
- out_pc  output  WIDTH  PC of instruction at FIFO head

Behaviour:
- Reset (asynchronous, active-high) values:
  - pc = RESET_PC
  - FIFO count = 0; read and write pointers = 0
  - out_valid = 0
  - out_instr = 0, out_pc = 0 (head storage cleared)
- rom_addr = pc, purely combinational. rom_rdata is sampled in the same cycle; there is no ROM latency.
- push = fetch_en & ~redirect_valid & (count < FIFO_DEPTH | pop).
  - Full with a simultaneous pop allows a push.
- pop = out_valid & out_ready & ~redirect_valid.
- On push:
  - FIFO[wptr] <= {pc, rom_rdata}
  - wptr advances
  - pc <= pc + 4, modulo 2^WIDTH; 32'hFFFF_FFFC wraps to 0 with no flag.
- On pop: rptr advances.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- out_valid = (count != 0). out_instr and out_pc come from FIFO[rptr], combinational from registers.
- First-fetch latency: out_valid rises one cycle after the first edge with fetch_en = 1, i.e. one-cycle fetch-to-decode latency.
- Redirect (highest priority):
  - On an edge with redirect_valid = 1: count, wptr and rptr <= 0; pc <= {redirect_pc[WIDTH-1:2], 2'b00}.
  - No push and no pop take effect that edge, regardless of out_ready.
  - out_valid = 0 the next cycle.
  - The target instruction appears with out_valid = 1 one cycle after that, if fetch_en = 1.
- Redirect held high for several cycles: the flush repeats each cycle, and pc tracks the latest redirect_pc.
- fetch_en = 0: pc holds and there are no pushes; buffered entries drain normally through pops. A redirect is still honoured.
- Reset asserted mid-operation: all state clears immediately; in-flight entries are discarded.
- Empty FIFO with out_ready = 1: no pop, pointers unchanged.
- No state machine beyond the FIFO occupancy. The states are EMPTY / PARTIAL / FULL, decoded from count.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_fetched [31:0], perf_stalls [31:0], perf_flushes [31:0].
  - perf_fetched increments on each push.
  - perf_stalls increments each cycle with fetch_en = 1, no redirect, and no push (FIFO full, no pop).
  - perf_flushes increments on each redirect edge.
  - All three reset to 0 and wrap at 2^32.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Sequential fetch:
  - Stimulus: reset, fetch_en = 1, out_ready = 1, ROM word n = 32'h1000_0000 + n.
  - Required response: rom_addr steps 0, 4, 8, …; out_pc = 0, 4, 8 on consecutive cycles starting one cycle after reset release; out_instr = 32'h1000_0000, 32'h1000_0001, …
- Backpressure:
  - Stimulus: out_ready = 0 for 5 cycles.
  - Required response: exactly FIFO_DEPTH (2) pushes, then pc holds at 8 and out_pc stays at 0.
  - Stimulus: out_ready = 1.
  - Required response: pop and push occur in the same cycle, and out_pc proceeds 0, 4, 8 with no gap or duplicate.
- Redirect while full:
  - Stimulus: FIFO full, redirect_valid = 1 with redirect_pc = 32'h0000_0103, out_ready = 1.
  - Required response: next cycle out_valid = 0 and rom_addr = 32'h100. Cycle after: out_pc = 32'h100. Neither stale entry is ever presented.
- PC wrap:
  - Stimulus: redirect to 32'hFFFF_FFFC.
  - Required response: out_pc = 32'hFFFF_FFFC, then out_pc = 0.
- fetch_en low and async reset:
  - Stimulus: fetch_en = 0 with 2 entries buffered.
  - Required response: entries drain; pc is unchanged; out_valid falls after 2 pops.
  - Stimulus: assert rst mid-cycle.
  - Required response: out_valid = 0 and rom_addr = RESET_PC immediately, with no clock edge needed.
- FETCH_PERF_EN:
  - Stimulus: 10 pushes, 3 stall cycles, 1 redirect.
  - Required response: perf_fetched = 10, perf_stalls = 3, perf_flushes = 1.
